// File: rtl/mips_pkg.sv
// Shared types and constants for the execute-stage hazard scheduler.
package mips_pkg;

    // Forwarding mux select encodings for the EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One in-flight instruction as seen by the scheduler. The uses_* bits
    // let the EX slot act as a consumer when the forwarding selects are built.
    typedef struct packed {
        logic       wr_valid;
        logic [4:0] dest;
        logic       is_load;
        logic       uses_rs;
        logic [4:0] rs;
        logic       uses_rt;
        logic [4:0] rt;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // A slot produces register r for a consumer that actually reads r.
    // $0 is never a producer, whatever the slot claims.
    function automatic logic slot_match(input slot_t s, input logic [4:0] r,
                                        input logic use_r);
        return s.wr_valid && (s.dest == r) && (r != REG_ZERO) && use_r;
    endfunction

endpackage

// File: rtl/dest_hazard_scheduler_slot.sv
// One pipeline slot of the shadow scoreboard: a registered entry that loads
// the upstream entry or a bubble every cycle, plus two match probes.
module dest_slot
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble_i,
    input  slot_t      slot_i,
    output slot_t      slot_o,
    input  logic [4:0] src_a_i,
    input  logic       use_a_i,
    input  logic [4:0] src_b_i,
    input  logic       use_b_i,
    output logic       hit_a_o,
    output logic       hit_b_o
);

    slot_t slot_q, slot_d;

    // Next entry: the upstream instruction, or an all-invalid bubble.
    always_comb begin
        slot_d = bubble_i ? SLOT_BUBBLE : slot_i;
    end

    // Slot register; reset discards whatever was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Does this slot produce either probed source register?
    always_comb begin
        hit_a_o = slot_match(slot_q, src_a_i, use_a_i);
        hit_b_o = slot_match(slot_q, src_b_i, use_b_i);
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/dest_hazard_scheduler.sv
// Execute-stage hazard scheduler: picks each instruction's destination,
// tracks writers in EX/MEM/WB, raises load-use (or no-forwarding) stalls
// and drives the EX operand forwarding selects.
module dest_hazard_scheduler
    import mips_pkg::*;
#(
    parameter int unsigned FORWARDING = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic             id_regdst,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [4:0]       ex_dest,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam bit               FWD_EN  = (FORWARDING != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            id_slot;
    slot_t            ex_q;
    slot_t            mem_q;
    slot_t            wb_slot_unused;   // WB contents only feed its own probes
    logic [4:0]       id_dest;
    logic             ex_bubble;
    logic             ex_hit_rs, ex_hit_rt;
    logic             mem_hit_rs, mem_hit_rt;
    logic             mem_fwd_a, mem_fwd_b;
    logic             wb_fwd_a, wb_fwd_b;
    logic             ex_load_use, ex_mem_dep, stall_raw;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Decode the ID instruction into a scoreboard entry.
    always_comb begin
        id_dest          = id_regdst ? id_rd : id_rt;
        id_slot          = SLOT_BUBBLE;
        id_slot.wr_valid = id_regwrite && (id_dest != REG_ZERO);
        id_slot.dest     = id_dest;
        id_slot.is_load  = id_memread;
        id_slot.uses_rs  = id_uses_rs;
        id_slot.rs       = id_rs;
        id_slot.uses_rt  = id_uses_rt;
        id_slot.rt       = id_rt;
    end

    // EX slot probes the ID sources for stall detection.
    dest_slot u_ex_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (ex_bubble),
        .slot_i   (id_slot),
        .slot_o   (ex_q),
        .src_a_i  (id_rs),
        .use_a_i  (id_uses_rs),
        .src_b_i  (id_rt),
        .use_b_i  (id_uses_rt),
        .hit_a_o  (ex_hit_rs),
        .hit_b_o  (ex_hit_rt)
    );

    // MEM and WB slots probe the EX consumer's sources for forwarding.
    dest_slot u_mem_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (1'b0),
        .slot_i   (ex_q),
        .slot_o   (mem_q),
        .src_a_i  (ex_q.rs),
        .use_a_i  (ex_q.uses_rs),
        .src_b_i  (ex_q.rt),
        .use_b_i  (ex_q.uses_rt),
        .hit_a_o  (mem_fwd_a),
        .hit_b_o  (mem_fwd_b)
    );

    dest_slot u_wb_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (1'b0),
        .slot_i   (mem_q),
        .slot_o   (wb_slot_unused),
        .src_a_i  (ex_q.rs),
        .use_a_i  (ex_q.uses_rs),
        .src_b_i  (ex_q.rt),
        .use_b_i  (ex_q.uses_rt),
        .hit_a_o  (wb_fwd_a),
        .hit_b_o  (wb_fwd_b)
    );

    // Without forwarding, an ID consumer also waits on a producer in MEM.
    always_comb begin
        mem_hit_rs = slot_match(mem_q, id_rs, id_uses_rs);
        mem_hit_rt = slot_match(mem_q, id_rt, id_uses_rt);
    end

    // Stall decision; a flush of the ID instruction always overrides it.
    always_comb begin
        ex_load_use = ex_q.is_load && (ex_hit_rs || ex_hit_rt);
        ex_mem_dep  = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
        stall_raw   = FWD_EN ? ex_load_use : ex_mem_dep;
        stall       = id_valid && !flush && stall_raw;
        ex_bubble   = stall || flush || !id_valid;
    end

    // Forwarding selects: MEM is the most recent producer, so it wins over WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (mem_fwd_a)     fwd_a = FWD_MEM;
            else if (wb_fwd_a) fwd_a = FWD_WB;
            if (mem_fwd_b)     fwd_b = FWD_MEM;
            else if (wb_fwd_b) fwd_b = FWD_WB;
        end
    end

    // Saturating stall-cycle counter next state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign ex_dest   = ex_q.dest;

endmodule

// File: tb/tb_dest_hazard_scheduler.sv
// Directed bench for dest_hazard_scheduler: one instance with forwarding,
// one without, both fed the same ID stream.
module tb_dest_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt, id_regwrite, id_regdst, id_memread;
    logic        flush;

    logic        stall1, stall0;
    logic [1:0]  fwd_a1, fwd_b1, fwd_a0, fwd_b0;
    logic [4:0]  ex_dest1, ex_dest0;
    logic [15:0] cnt1, cnt0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dest_hazard_scheduler #(.FORWARDING(1), .CNT_W(16)) u_dut_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_regdst(id_regdst), .id_memread(id_memread),
        .flush(flush), .stall(stall1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .ex_dest(ex_dest1), .stall_cnt(cnt1)
    );

    dest_hazard_scheduler #(.FORWARDING(0), .CNT_W(16)) u_dut_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_regdst(id_regdst), .id_memread(id_memread),
        .flush(flush), .stall(stall0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .ex_dest(ex_dest0), .stall_cnt(cnt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic urs, input logic urt, input logic rw,
                          input logic rdst, input logic mr);
        id_valid    = 1'b1;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_regwrite = rw;
        id_regdst   = rdst;
        id_memread  = mr;
        flush       = 1'b0;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_rd       = 5'd0;
        id_uses_rs  = 1'b0;
        id_uses_rt  = 1'b0;
        id_regwrite = 1'b0;
        id_regdst   = 1'b0;
        id_memread  = 1'b0;
        flush       = 1'b0;
    endtask

    // Advance one clock and sample away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // 1: idle after reset
        check("rst_stall1",  32'(stall1),   32'd0);
        check("rst_fwd_a1",  32'(fwd_a1),   32'd0);
        check("rst_fwd_b1",  32'(fwd_b1),   32'd0);
        check("rst_ex_dest1", 32'(ex_dest1), 32'd0);
        check("rst_cnt1",    32'(cnt1),     32'd0);
        check("rst_stall0",  32'(stall0),   32'd0);
        check("rst_cnt0",    32'(cnt0),     32'd0);
        tick();

        // 2: add $3,$1,$2 ; sub $4,$3,$5 ; and $9,$6,$3
        set_id(5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0);
        #1;
        check("add_stall", 32'(stall1), 32'd0);
        tick();
        check("add_ex_dest", 32'(ex_dest1), 32'd3);
        set_id(5'd3, 5'd5, 5'd4, 1, 1, 1, 1, 0);
        #1;
        check("sub_no_stall", 32'(stall1), 32'd0);
        tick();
        set_id(5'd6, 5'd3, 5'd9, 1, 1, 1, 1, 0);
        #1;
        check("sub_fwd_a_mem", 32'(fwd_a1), 32'(2'b10));
        check("sub_fwd_b_rf",  32'(fwd_b1), 32'(2'b00));
        check("and_no_stall",  32'(stall1), 32'd0);
        tick();
        idle();
        #1;
        check("and_fwd_a_rf", 32'(fwd_a1),   32'(2'b00));
        check("and_fwd_b_wb", 32'(fwd_b1),   32'(2'b01));
        check("and_ex_dest",  32'(ex_dest1), 32'd9);
        tick(); tick(); tick();

        // 3: lw $6,0($1) ; add $7,$6,$1
        set_id(5'd1, 5'd6, 5'd0, 1, 0, 1, 0, 1);
        #1;
        check("lw_no_stall", 32'(stall1), 32'd0);
        tick();
        check("lw_ex_dest", 32'(ex_dest1), 32'd6);
        set_id(5'd6, 5'd1, 5'd7, 1, 1, 1, 1, 0);
        #1;
        check("lu_stall", 32'(stall1), 32'd1);
        tick();
        check("lu_bubble_dest", 32'(ex_dest1), 32'd0);
        check("lu_stall_once",  32'(stall1),   32'd0);
        check("lu_cnt",         32'(cnt1),     32'd1);
        tick();
        idle();
        #1;
        check("lu_fwd_a_wb",   32'(fwd_a1),   32'(2'b01));
        check("lu_fwd_b_rf",   32'(fwd_b1),   32'(2'b00));
        check("lu_add_dest",   32'(ex_dest1), 32'd7);
        check("lu_cnt_hold",   32'(cnt1),     32'd1);
        tick(); tick(); tick();

        // 4: lw $0 then a consumer of $0: never a hazard
        set_id(5'd1, 5'd0, 5'd0, 1, 0, 1, 0, 1);
        tick();
        set_id(5'd0, 5'd0, 5'd5, 1, 1, 1, 1, 0);
        #1;
        check("r0_no_stall", 32'(stall1), 32'd0);
        tick();
        idle();
        #1;
        check("r0_fwd_a", 32'(fwd_a1), 32'(2'b00));
        check("r0_fwd_b", 32'(fwd_b1), 32'(2'b00));
        tick(); tick(); tick();

        // 6a: load-use with flush in the same cycle
        set_id(5'd1, 5'd6, 5'd0, 1, 0, 1, 0, 1);
        tick();
        set_id(5'd2, 5'd6, 5'd8, 1, 1, 1, 1, 0);
        flush = 1'b1;
        #1;
        check("flush_no_stall", 32'(stall1), 32'd0);
        tick();
        idle();
        #1;
        check("flush_bubble_dest", 32'(ex_dest1), 32'd0);
        check("flush_cnt_hold",    32'(cnt1),     32'd1);
        tick(); tick(); tick();

        // 6b: reset asserted in the middle of a stall
        set_id(5'd1, 5'd6, 5'd0, 1, 0, 1, 0, 1);
        tick();
        set_id(5'd6, 5'd1, 5'd7, 1, 1, 1, 1, 0);
        #1;
        check("pre_rst_stall", 32'(stall1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall",   32'(stall1),   32'd0);
        check("midrst_ex_dest", 32'(ex_dest1), 32'd0);
        check("midrst_cnt",     32'(cnt1),     32'd0);
        check("midrst_fwd_a",   32'(fwd_a1),   32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // 5: no forwarding: add $3 ; sub $4,$3,$5 -> two stall cycles
        set_id(5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0);
        #1;
        check("nf_add_stall", 32'(stall0), 32'd0);
        tick();
        set_id(5'd3, 5'd5, 5'd4, 1, 1, 1, 1, 0);
        #1;
        check("nf_stall_c1",   32'(stall0), 32'd1);
        check("nf_fwd_a_c1",   32'(fwd_a0), 32'd0);
        check("fw_no_stall",   32'(stall1), 32'd0);
        tick();
        check("nf_stall_c2", 32'(stall0), 32'd1);
        check("nf_cnt_c2",   32'(cnt0),   32'd1);
        check("nf_fwd_a_c2", 32'(fwd_a0), 32'd0);
        tick();
        check("nf_stall_c3", 32'(stall0), 32'd0);
        check("nf_cnt_c3",   32'(cnt0),   32'd2);
        tick();
        idle();
        #1;
        check("nf_sub_dest",  32'(ex_dest0), 32'd4);
        check("nf_sub_fwd_a", 32'(fwd_a0),   32'd0);
        check("nf_sub_fwd_b", 32'(fwd_b0),   32'd0);
        check("nf_cnt_final", 32'(cnt0),     32'd2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
